alu_issue_unit: RTL and testbench

Initiator/sequencer that sits in front of the combinational 64-bit ALU and drives it.
- Accepts operation requests (operands, 5-bit function code, tag) over a valid/ready handshake.
- Registers and drives the ALU operand/function inputs, then captures the ALU result and flags one cycle later.
- Returns them on a valid/ready response channel, with illegal-function detection and completion counters.
- Used by the datapath controller so the ALU's combinational path is cut by registers on both sides.

---
 rtl/alu_issue_unit.sv | 177 +++++++++++++++++
 tb/tb_alu_issue_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Issue/sequencer in front of the combinational ALU: registers
// operands on accept, captures the result one cycle later.
module alu_issue_unit #(
  parameter int WIDTH  = 64,
  parameter int FN_W   = 5,
  parameter int MAX_FN = 8,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_in1,
  input  logic [WIDTH-1:0] req_in2,
  input  logic [FN_W-1:0]  req_fn,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [FN_W-1:0]  alu_fn,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_cout,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             en_q;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [FN_W-1:0]  fn_q, fn_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             rill_q, rill_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;

  logic accept;
  logic hs;

  // en_q keeps req_ready low until the first edge after reset release
  assign req_ready = en_q & ((state_q == IDLE) |
                     ((state_q == RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;
  assign hs        = vld_q & rsp_ready;

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    fn_d    = fn_q;
    tag_d   = tag_q;
    ill_d   = ill_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    rill_d  = rill_q;
    rtag_d  = rtag_q;
    vld_d   = vld_q;
    done_d  = done_q;
    icnt_d  = icnt_q;

    if (accept) begin
      in1_d = req_in1;
      in2_d = req_in2;
      fn_d  = req_fn;
      tag_d = req_tag;
      ill_d = (req_fn > FN_W'(MAX_FN));
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        res_d   = ill_q ? '0 : alu_out;
        zero_d  = ~ill_q & alu_zero;
        ovf_d   = ~ill_q & alu_overflow;
        cout_d  = ~ill_q & alu_cout;
        rill_d  = ill_q;
        rtag_d  = tag_q;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (hs) begin
          done_d = done_q + CNT_W'(1);
          if (rill_q && (icnt_q != '1))
            icnt_d = icnt_q + CNT_W'(1);
          vld_d   = 1'b0;
          state_d = accept ? EXEC : IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      fn_q    <= '0;
      tag_q   <= '0;
      ill_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      rill_q  <= 1'b0;
      rtag_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      fn_q    <= fn_d;
      tag_q   <= tag_d;
      ill_q   <= ill_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      rill_q  <= rill_d;
      rtag_q  <= rtag_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      icnt_q  <= icnt_d;
    end
  end

  assign alu_in1       = in1_q;
  assign alu_in2       = in2_q;
  assign alu_fn        = fn_q;
  assign rsp_valid     = vld_q;
  assign rsp_result    = res_q;
  assign rsp_zero      = zero_q;
  assign rsp_overflow  = ovf_q;
  assign rsp_cout      = cout_q;
  assign rsp_illegal   = rill_q;
  assign rsp_tag       = rtag_q;
  assign busy          = (state_q != IDLE);
  assign done_count    = done_q;
  assign illegal_count = icnt_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU stub plus
// a reference model of the expected responses.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_in1 = '0;
  logic [63:0] req_in2 = '0;
  logic [4:0]  req_fn = '0;
  logic [3:0]  req_tag = '0;
  logic [63:0] alu_in1, alu_in2;
  logic [4:0]  alu_fn;
  logic [63:0] alu_out;
  logic        alu_zero, alu_overflow, alu_cout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic        rsp_zero, rsp_overflow, rsp_cout, rsp_illegal;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [15:0] done_count, illegal_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_done = 0;
  int exp_ill = 0;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        o;
    logic        c;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .req_fn(req_fn), .req_tag(req_tag),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_fn(alu_fn),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout),
    .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .busy(busy), .done_count(done_count),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  // ALU arithmetic: {result, zero, overflow, carry}
  function automatic logic [66:0] alu_beh(
    input logic [63:0] a, input logic [63:0] b, input logic [4:0] f);
    logic [64:0] s;
    logic [63:0] r;
    logic o, c;
    o = 1'b0;
    c = 1'b0;
    case (f)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0];
        c = s[64];
        o = (a[63] == b[63]) && (r[63] != a[63]);
      end
      5'd1: begin
        r = a - b;
        c = (a < b);
        o = (a[63] != b[63]) && (r[63] != a[63]);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = ~a;
      5'd6: r = ~(a & b);
      5'd7: r = ~(a | b);
      5'd8: r = ~(a ^ b);
      default: return {64'hDEAD_BEEF_0BAD_F00D, 3'b111};
    endcase
    return {r, (r == 64'd0), o, c};
  endfunction

  always_comb begin
    {alu_out, alu_zero, alu_overflow, alu_cout} =
      alu_beh(alu_in1, alu_in2, alu_fn);
  end

  function automatic exp_t model(
    input logic [63:0] a, input logic [63:0] b,
    input logic [4:0] f, input logic [3:0] t);
    exp_t e;
    if (f > 5'd8) e = {64'd0, 3'b000, 1'b1, t};
    else e = {alu_beh(a, b, f), 1'b0, t};
    return e;
  endfunction

  function automatic exp_t rsp_now();
    return {rsp_result, rsp_zero, rsp_overflow, rsp_cout,
            rsp_illegal, rsp_tag};
  endfunction

  task automatic count_hs(input logic ill);
    exp_done = (exp_done + 1) % 65536;
    if (ill && exp_ill < 65535) exp_ill++;
  endtask

  // one op: accept, 1-cycle latency, optional stall, handshake
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] f, input logic [3:0] t,
                        input int stall);
    exp_t e;
    bit   got;
    e = model(a, b, f, t);
    @(negedge clk);
    req_valid = 1'b1;
    req_in1 = a; req_in2 = b; req_fn = f; req_tag = t;
    rsp_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin got = 1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if ({alu_in1, alu_in2, alu_fn, rsp_valid, busy} !==
        {a, b, f, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL exec_state: in1=%h in2=%h fn=%0d v=%0b busy=%0b required %h %h %0d 0 1",
               alu_in1, alu_in2, alu_fn, rsp_valid, busy, a, b, f);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_now()} !== {1'b1, e}) begin
      n_bad++;
      $display("FAIL rsp_fields: v=%0b got=%h required %h",
               rsp_valid, rsp_now(), e);
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_now()} !== {2'b10, e}) begin
        n_bad++;
        $display("FAIL stall_hold: v=%0b rdy=%0b got=%h required 1 0 %h",
                 rsp_valid, req_ready, rsp_now(), e);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    count_hs(e.ill);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy, done_count, illegal_count, rsp_now()} !==
        {2'b00, 16'(exp_done), 16'(exp_ill), e}) begin
      n_bad++;
      $display("FAIL after_hs: v=%0b busy=%0b done=%0d ill=%0d got=%h required 0 0 %0d %0d %h",
               rsp_valid, busy, done_count, illegal_count, rsp_now(),
               exp_done, exp_ill, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, busy, done_count, illegal_count,
         alu_in1, alu_in2, alu_fn, rsp_now()} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%0b v=%0b busy=%0b done=%0d in1=%h rsp=%h required all 0",
               req_ready, rsp_valid, busy, done_count, alu_in1, rsp_now());
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%0b busy=%0b required 1 0",
               req_ready, busy);
    end
  endtask

  task automatic test_directed();
    run_op(64'd5, 64'd3, 5'd0, 4'hA, 0);
    n_cmp++;
    if ({rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_tag,
         done_count} !== {64'd8, 3'b000, 4'hA, 16'd1}) begin
      n_bad++;
      $display("FAIL add_legal: res=%h z=%0b c=%0b o=%0b tag=%h done=%0d required 8 0 0 0 a 1",
               rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_tag,
               done_count);
    end
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 4'h1, 1);
    n_cmp++;
    if ({rsp_result, rsp_zero, rsp_cout, rsp_overflow} !==
        {64'd0, 3'b110}) begin
      n_bad++;
      $display("FAIL add_carry: res=%h z=%0b c=%0b o=%0b required 0 1 1 0",
               rsp_result, rsp_zero, rsp_cout, rsp_overflow);
    end
    run_op(64'h8000_0000_0000_0000, 64'd1, 5'd1, 4'h2, 0);
    n_cmp++;
    if ({rsp_result, rsp_zero, rsp_cout, rsp_overflow} !==
        {64'h7FFF_FFFF_FFFF_FFFF, 3'b001}) begin
      n_bad++;
      $display("FAIL sub_overflow: res=%h z=%0b c=%0b o=%0b required 7fffffffffffffff 0 0 1",
               rsp_result, rsp_zero, rsp_cout, rsp_overflow);
    end
    run_op(64'd7, 64'd7, 5'd9, 4'h3, 2);
    n_cmp++;
    if ({rsp_illegal, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
         illegal_count} !== {1'b1, 64'd0, 3'b000, 16'd1}) begin
      n_bad++;
      $display("FAIL illegal_fn: ill=%0b res=%h z=%0b c=%0b o=%0b icnt=%0d required 1 0 0 0 0 1",
               rsp_illegal, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
               illegal_count);
    end
  endtask

  task automatic test_backpressure();
    exp_t e0, e1;
    e0 = model(64'd10, 64'd20, 5'd0, 4'h3);
    e1 = model(64'hF0, 64'hFF, 5'd4, 4'h5);
    @(negedge clk);
    req_valid = 1'b1;
    req_in1 = 64'd10; req_in2 = 64'd20; req_fn = 5'd0; req_tag = 4'h3;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_in1 = 64'hF0; req_in2 = 64'hFF; req_fn = 5'd4; req_tag = 4'h5;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready, alu_in1, rsp_now()} !==
          {2'b10, 64'd10, e0}) begin
        n_bad++;
        $display("FAIL bp_hold: v=%0b rdy=%0b in1=%h got=%h required 1 0 a %h",
                 rsp_valid, req_ready, alu_in1, rsp_now(), e0);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ready_comb: rdy=%0b required 1", req_ready);
    end
    @(posedge clk);
    count_hs(1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy, alu_in1, alu_fn, done_count} !==
        {2'b01, 64'hF0, 5'd4, 16'(exp_done)}) begin
      n_bad++;
      $display("FAIL handoff: v=%0b busy=%0b in1=%h fn=%0d done=%0d required 0 1 f0 4 %0d",
               rsp_valid, busy, alu_in1, alu_fn, done_count, exp_done);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_now()} !==
        {1'b1, 64'h0F, e1}) begin
      n_bad++;
      $display("FAIL handoff_rsp: v=%0b got=%h required 1 %h",
               rsp_valid, rsp_now(), e1);
    end
    @(posedge clk);
    count_hs(1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy, done_count} !== {2'b00, 16'(exp_done)}) begin
      n_bad++;
      $display("FAIL bp_idle: v=%0b busy=%0b done=%0d required 0 0 %0d",
               rsp_valid, busy, done_count, exp_done);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 10;
    logic [63:0] a[N], b[N];
    logic [4:0]  f[N];
    logic [3:0]  t[N];
    exp_t e;
    for (int i = 0; i < N; i++) begin
      a[i] = {$urandom, $urandom};
      b[i] = {$urandom, $urandom};
      f[i] = 5'($urandom_range(0, 11));
      t[i] = 4'($urandom);
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_in1 = a[0]; req_in2 = b[0]; req_fn = f[0]; req_tag = t[0];
    rsp_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, alu_in1, alu_in2, alu_fn} !==
          {1'b0, a[i], b[i], f[i]}) begin
        n_bad++;
        $display("FAIL b2b_exec[%0d]: v=%0b in1=%h fn=%0d required 0 %h %0d",
                 i, rsp_valid, alu_in1, alu_fn, a[i], f[i]);
      end
      if (i < N - 1) begin
        req_in1 = a[i+1]; req_in2 = b[i+1];
        req_fn = f[i+1]; req_tag = t[i+1];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      e = model(a[i], b[i], f[i], t[i]);
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_now()} !== {2'b11, e}) begin
        n_bad++;
        $display("FAIL b2b_rsp[%0d]: v=%0b rdy=%0b got=%h required 1 1 %h",
                 i, rsp_valid, req_ready, rsp_now(), e);
      end
      @(posedge clk);
      count_hs(e.ill);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({busy, done_count, illegal_count} !==
        {1'b0, 16'(exp_done), 16'(exp_ill)}) begin
      n_bad++;
      $display("FAIL b2b_counts: busy=%0b done=%0d ill=%0d required 0 %0d %0d",
               busy, done_count, illegal_count, exp_done, exp_ill);
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 64'h8000_0000_0000_0000;
      run_op(a, b, 5'($urandom_range(0, 12)), 4'($urandom),
             int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_in1 = 64'd9; req_in2 = 64'd4; req_fn = 5'd1; req_tag = 4'h7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_done = 0;
    exp_ill = 0;
    n_cmp++;
    if ({rsp_valid, busy, req_ready, done_count, illegal_count,
         alu_in1, alu_in2, alu_fn} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: v=%0b busy=%0b rdy=%0b done=%0d in1=%h fn=%0d required all 0",
               rsp_valid, busy, req_ready, done_count, alu_in1, alu_fn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'd1, 64'd1, 5'd0, 4'h4, 0);
    n_cmp++;
    if ({rsp_result, done_count} !== {64'd2, 16'd1}) begin
      n_bad++;
      $display("FAIL post_reset_add: res=%h done=%0d required 2 1",
               rsp_result, done_count);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
